audio_smpl_queue: RTL and testbench

Dual-channel circular sample queue that stores the newest DEPTH left/right audio samples from the codec interface. After each accepted write with the queue full, it replays all DEPTH samples oldest-to-newest on a `sequencing` burst. It is the producer side of the FIR band filters' `sequencing`/sample interface: one queue feeds all band FIRs in parallel.

---
 rtl/audio_eq_pkg.sv | 19 +
 rtl/smpl_dpram.sv | 34 +++
 rtl/audio_smpl_queue.sv | 143 ++++++++++++++
 tb/tb_audio_smpl_queue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/audio_eq_pkg.sv
// Shared constants and types for the audio equaliser sample path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package audio_eq_pkg;

    // Sample width of both codec channels
    localparam int SMPL_W = 16;

    // Default history depth; also sizes the FIR coefficient ROMs
    localparam int DFLT_DEPTH = 1024;

    // Sample queue control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        READ = 2'd2
    } smpl_state_e;

endpackage

// File: rtl/smpl_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port, no reset.
// Latency: read data appears one clock after rd_en_i/rd_addr_i; write visible next cycle.
// Backpressure: none; read data register holds its value while rd_en_i is low.
module smpl_dpram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DAT_W  = 32
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DAT_W-1:0]  wr_dat_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DAT_W-1:0]  rd_dat_o
);

    logic [DAT_W-1:0] mem_q [DEPTH];

    // Store one sample pair per write strobe
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    // Registered read; output holds between reads so the last sample stays visible
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_dat_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/audio_smpl_queue.sv
// Dual-channel circular queue of the newest DEPTH samples; replays them oldest-first on each full write.
// Latency: sequencing rises the cycle after the filling write; sample k arrives on burst cycle k+1 (DEPTH+1 cycles).
// Backpressure: none; writes arriving during a burst are dropped (sticky ovr when SMPL_OVR_FLAG_EN is defined).
module audio_smpl_queue
    import audio_eq_pkg::*;
#(
    parameter int DEPTH  = DFLT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wrt_smpl,
    input  logic signed [SMPL_W-1:0] lft_smpl,
    input  logic signed [SMPL_W-1:0] rght_smpl,
    output logic                     sequencing,
    output logic signed [SMPL_W-1:0] lft_out,
    output logic signed [SMPL_W-1:0] rght_out,
    output logic                     ovr
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    smpl_state_e         state_q;
    logic                seq_q;
    logic                out_vld_q;
    logic [ADDR_W-1:0]   new_ptr_q, new_ptr_d;
    logic [ADDR_W-1:0]   old_ptr_q, old_ptr_d;
    logic [ADDR_W:0]     count_q,   count_d;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [ADDR_W-1:0]   rd_cnt_q;

    logic                wr_acc;
    logic                rd_en;
    logic [2*SMPL_W-1:0] rd_dat;

    // Writes are only taken while idle; anything else during a burst is dropped
    assign wr_acc = (state_q == IDLE) && wrt_smpl;

    // One read per sample: issued in PRE and all but the last READ cycle, so the newest sample stays on the outputs
    assign rd_en = (state_q == PRE) || ((state_q == READ) && (rd_cnt_q != LAST_CNT));

    // Pointer and occupancy update for an accepted write; the oldest entry is evicted once full
    always_comb begin
        new_ptr_d = new_ptr_q;
        old_ptr_d = old_ptr_q;
        count_d   = count_q;
        if (wr_acc) begin
            new_ptr_d = new_ptr_q + ADDR_W'(1);
            if (count_q == DEPTH_C) begin
                old_ptr_d = old_ptr_q + ADDR_W'(1);
            end else begin
                count_d = count_q + (ADDR_W+1)'(1);
            end
        end
    end

    // Control FSM with registered sequencing; read pointer walks oldest to newest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            seq_q     <= 1'b0;
            out_vld_q <= 1'b0;
            new_ptr_q <= '0;
            old_ptr_q <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            new_ptr_q <= new_ptr_d;
            old_ptr_q <= old_ptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_q | rd_en;
            case (state_q)
                IDLE: begin
                    if (wr_acc && (count_d == DEPTH_C)) begin
                        state_q  <= PRE;
                        seq_q    <= 1'b1;
                        rd_ptr_q <= old_ptr_d;
                    end
                end
                PRE: begin
                    state_q  <= READ;
                    rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                    rd_cnt_q <= '0;
                end
                READ: begin
                    if (rd_en) begin
                        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                    end
                    if (rd_cnt_q == LAST_CNT) begin
                        state_q <= IDLE;
                        seq_q   <= 1'b0;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    seq_q   <= 1'b0;
                end
            endcase
        end
    end

    smpl_dpram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DAT_W  (2*SMPL_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (new_ptr_q),
        .wr_dat_i  ({lft_smpl, rght_smpl}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_dat_o  (rd_dat)
    );

    assign sequencing = seq_q;

    // RAM output is unreset, so present zero until the first read after reset has landed
    assign lft_out  = out_vld_q ? $signed(rd_dat[2*SMPL_W-1:SMPL_W]) : '0;
    assign rght_out = out_vld_q ? $signed(rd_dat[SMPL_W-1:0])        : '0;

`ifdef SMPL_OVR_FLAG_EN
    logic ovr_q;

    // Sticky flag: set whenever a write strobe is dropped during a burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (wrt_smpl && (state_q != IDLE)) begin
            ovr_q <= 1'b1;
        end
    end

    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_audio_smpl_queue.sv
// Bench for audio_smpl_queue at DEPTH=8: directed sequence with random data and gaps vs a history model.
// Latency: checks burst alignment one cycle after each filling write.
// Backpressure: injects writes mid-burst and expects them to be dropped.
module tb_audio_smpl_queue;

    localparam int DEPTH = 8;
`ifdef SMPL_OVR_FLAG_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wrt_smpl;
    logic signed [15:0] lft_smpl;
    logic signed [15:0] rght_smpl;
    logic               sequencing;
    logic signed [15:0] lft_out;
    logic signed [15:0] rght_out;
    logic               ovr;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: every accepted sample pair since reset, {L,R}
    logic [31:0] hist[$];
    logic        ovr_exp = 1'b0;

    audio_smpl_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wrt_smpl),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .sequencing (sequencing),
        .lft_out    (lft_out),
        .rght_out   (rght_out),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_seq", {31'b0, sequencing}, 32'd0);
        end
    endtask

    // Called at the negedge of burst cycle 0. inj: cycle on which a write is
    // attempted mid-burst; rst_at: cycle on which reset is asserted (-1 = never).
    task automatic run_burst(input int inj, input int rst_at);
        int base;
        base = hist.size() - DEPTH;
        for (int c = 0; c <= DEPTH; c++) begin
            if (c > 0) @(negedge clk);
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_seq",  {31'b0, sequencing}, 32'd0);
                chk("rst_lft",  {16'b0, lft_out},  32'd0);
                chk("rst_rght", {16'b0, rght_out}, 32'd0);
                chk("rst_ovr",  {31'b0, ovr},      32'd0);
                hist.delete();
                ovr_exp = 1'b0;
                wrt_smpl = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            chk("burst_seq", {31'b0, sequencing}, 32'd1);
            if (c > 0) begin
                chk("burst_lft",  {16'b0, lft_out},  {16'b0, hist[base + c - 1][31:16]});
                chk("burst_rght", {16'b0, rght_out}, {16'b0, hist[base + c - 1][15:0]});
            end
            if (c == inj) begin
                wrt_smpl  = 1'b1;
                lft_smpl  = 16'sh7FFF;
                rght_smpl = 16'sh1234;
                ovr_exp   = OVR_EN;
            end
            if (c == inj + 1) wrt_smpl = 1'b0;
        end
        @(negedge clk);
        wrt_smpl = 1'b0;
        chk("post_seq",  {31'b0, sequencing}, 32'd0);
        chk("hold_lft",  {16'b0, lft_out},  {16'b0, hist[hist.size()-1][31:16]});
        chk("hold_rght", {16'b0, rght_out}, {16'b0, hist[hist.size()-1][15:0]});
        chk("ovr",       {31'b0, ovr},      {31'b0, ovr_exp});
    endtask

    // Called at a negedge; leaves the bench at a negedge with wrt_smpl low
    task automatic do_write(input logic [15:0] l, input logic [15:0] r, input int inj, input int rst_at);
        lft_smpl  = l;
        rght_smpl = r;
        wrt_smpl  = 1'b1;
        @(negedge clk);
        wrt_smpl = 1'b0;
        hist.push_back({l, r});
        if (hist.size() >= DEPTH) run_burst(inj, rst_at);
        else chk("nofill_seq", {31'b0, sequencing}, 32'd0);
    endtask

    task automatic rand_write(input int inj, input int rst_at);
        logic [31:0] rv;
        rv = $urandom();
        do_write(rv[31:16], rv[15:0], inj, rst_at);
    endtask

    initial begin
        rst_n     = 1'b0;
        wrt_smpl  = 1'b0;
        lft_smpl  = '0;
        rght_smpl = '0;
        repeat (2) @(negedge clk);
        chk("reset_seq",  {31'b0, sequencing}, 32'd0);
        chk("reset_lft",  {16'b0, lft_out},  32'd0);
        chk("reset_rght", {16'b0, rght_out}, 32'd0);
        chk("reset_ovr",  {31'b0, ovr},      32'd0);
        rst_n = 1'b1;
        idle(5);

        // Fill: L=k, R=-k; the 8th write starts the first burst
        for (int k = 1; k <= 8; k++) begin
            do_write(16'(k), 16'(-k), -1, -1);
            idle($urandom_range(0, 2));
        end

        // Wrap: writes 9..20, each one replays the newest eight
        for (int k = 9; k <= 20; k++) begin
            do_write(16'(k), 16'(-k), -1, -1);
            idle($urandom_range(0, 2));
        end

        // Overrun attempt during burst cycle 3; the next burst must not contain it
        rand_write(3, -1);
        idle(1);
        rand_write(-1, -1);
        chk("ovr_after", {31'b0, ovr}, {31'b0, OVR_EN});

        // Reset mid-burst on cycle 4, then refill from empty
        rand_write(-1, 4);
        for (int k = 0; k < DEPTH - 1; k++) begin
            rand_write(-1, -1);
            idle($urandom_range(0, 2));
        end
        rand_write(-1, -1);

        // Back-to-back: write on the first idle cycle after the burst
        do_write(16'h8000, 16'h0001, -1, -1);
        do_write(16'h8001, 16'hFFFF, -1, -1);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
